// File: rtl/cdc_handshake_rx.sv
// Receive side of a four-phase req/ack clock-domain crossing: synchronizes the
// request, captures the sender's held data word and hands it to a valid/ready consumer.
module cdc_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              async_req,
  input  logic [DATA_W-1:0] async_data,
  output logic              ack_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       xfer_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DELIVER  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   capture_en;
  logic                   accept;
  logic                   release_ack;

  // Only the last stage of the chain is ever looked at by the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The CAPTURE dwell buys async_data one extra cycle of settle time beyond the sync chain
  always_comb begin
    state_d     = state_q;
    capture_en  = 1'b0;
    accept      = 1'b0;
    release_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = DELIVER;
      end
      DELIVER: begin
        if (out_valid && out_ready) begin
          accept  = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          release_ack = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // out_data is only written on capture so it keeps the last word while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      ack_out    <= 1'b0;
      xfer_count <= 16'd0;
    end else begin
      if (capture_en) begin
        out_data  <= async_data;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        ack_out    <= 1'b1;
        xfer_count <= xfer_count + 16'd1;
      end else if (release_ack) begin
        ack_out <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx: directed boundary cases plus randomized
// transfers scored against a queue-based model of the four-phase protocol.
`timescale 1ns/1ps
module tb_cdc_handshake_rx;

  localparam int DATA_W = 8;
  localparam int S      = 3;

  logic              clk;
  logic              rst;
  logic              async_req;
  logic [DATA_W-1:0] async_data;
  logic              ack_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic [15:0]       xfer_count;

  int                checks;
  int                failures;
  int                model_count;
  logic [DATA_W-1:0] sb_q[$];
  logic              rand_ready;

  cdc_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .async_req  (async_req),
    .async_data (async_data),
    .ack_out    (ack_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Sender raises a request with a held word; the model expects that word delivered once
  task automatic applyStimulus(input logic [DATA_W-1:0] data);
    async_data = data;
    async_req  = 1'b1;
    sb_q.push_back(data);
  endtask

  // Reset discards anything in flight; a still-high request is delivered afresh
  task automatic modelReset();
    sb_q.delete();
    model_count = 0;
    if (async_req) sb_q.push_back(async_data);
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < limit);
    if (!out_valid) checkOutput("timeout_valid", 32'd0, 32'd1);
  endtask

  task automatic waitAck(input logic level, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack_out !== level && n < limit);
    if (ack_out !== level) checkOutput("timeout_ack", {31'd0, ack_out}, {31'd0, level});
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] data);
    int n;
    applyStimulus(data);
    waitAck(1'b1, 300, n);
    async_req = 1'b0;
    waitAck(1'b0, 300, n);
  endtask

  // Scoreboard: a handshake seen between edges is an acceptance at the next edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("sb_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
      end
      model_count = (model_count + 1) % 65536;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [DATA_W-1:0] w;
    checks      = 0;
    failures    = 0;
    model_count = 0;
    rand_ready  = 1'b0;
    rst         = 1'b1;
    async_req   = 1'b1;
    async_data  = 8'h5A;
    out_ready   = 1'b1;

    // Reset with request already high
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", {31'd0, ack_out}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_count", {16'd0, xfer_count}, 32'd0);
    rst = 1'b0;
    modelReset();
    waitValid(40, n);
    checkOutput("rst_valid_latency", n, S + 2);
    checkOutput("rst_valid_data", {24'd0, out_data}, 32'h5A);
    waitAck(1'b1, 40, n);
    async_req = 1'b0;
    waitAck(1'b0, 40, n);
    checkOutput("rst_count_after", {16'd0, xfer_count}, model_count);

    // Single transfer with exact latencies
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(8'hA5);
    waitValid(40, n);
    checkOutput("single_valid_latency", n, S + 2);
    checkOutput("single_data", {24'd0, out_data}, 32'hA5);
    checkOutput("single_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    checkOutput("single_ack", {31'd0, ack_out}, 32'd1);
    checkOutput("single_count", {16'd0, xfer_count}, model_count);
    async_req = 1'b0;
    waitAck(1'b0, 40, n);
    checkOutput("single_ack_fall", n, S + 1);
    checkOutput("single_idle", {31'd0, busy}, 32'd0);
    checkOutput("single_data_hold", {24'd0, out_data}, 32'hA5);

    // Backpressure
    out_ready = 1'b0;
    applyStimulus(8'h3C);
    waitValid(40, n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_data", {24'd0, out_data}, 32'h3C);
      checkOutput("bp_ack", {31'd0, ack_out}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_ack_release", {31'd0, ack_out}, 32'd1);
    async_req = 1'b0;
    waitAck(1'b0, 40, n);

    // Back-to-back with an immediately reacting sender
    for (int i = 1; i <= 4; i++) sendWord(i[DATA_W-1:0]);
    checkOutput("b2b_drained", sb_q.size(), 32'd0);
    checkOutput("b2b_count", {16'd0, xfer_count}, model_count);

    // Reset in DELIVER with request still high
    out_ready = 1'b0;
    w = $urandom_range(1, 255);
    applyStimulus(w);
    waitValid(40, n);
    rst = 1'b1;
    #1;
    checkOutput("mid_ack", {31'd0, ack_out}, 32'd0);
    checkOutput("mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_data", {24'd0, out_data}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_count", {16'd0, xfer_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    out_ready = 1'b1;
    waitAck(1'b1, 40, n);
    async_req = 1'b0;
    waitAck(1'b0, 40, n);
    checkOutput("mid_redeliver_count", {16'd0, xfer_count}, 32'd1);
    checkOutput("mid_model_count", {16'd0, xfer_count}, model_count);

    // Request withdrawn before acceptance
    out_ready = 1'b0;
    applyStimulus($urandom_range(0, 255));
    waitValid(40, n);
    async_req = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    checkOutput("viol_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("viol_ack_high", {31'd0, ack_out}, 32'd1);
    @(posedge clk); #1;
    checkOutput("viol_ack_low", {31'd0, ack_out}, 32'd0);
    checkOutput("viol_idle", {31'd0, busy}, 32'd0);

    // Counter wrap
    force dut.xfer_count = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_count;
    model_count = 65535;
    sendWord($urandom_range(0, 255));
    checkOutput("wrap_count", {16'd0, xfer_count}, 32'd0);
    checkOutput("wrap_model", {16'd0, xfer_count}, model_count);

    // Randomized transfers with random consumer stalls and sender gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sendWord($urandom_range(0, 255));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    checkOutput("rand_drained", sb_q.size(), 32'd0);
    checkOutput("rand_count", {16'd0, xfer_count}, model_count);
    checkOutput("rand_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
